// File: rtl/bsg_fifo_rolly_read_ctrl.sv
// Read-side controller for the rolly FIFO: speculative dequeue, outstanding window, retry limit.
// Define BSG_FIFO_ROLLY_READ_CTRL_TIMEOUT_EN to enable idle-timeout self-rollback.
module bsg_fifo_rolly_read_ctrl #(
   parameter int unsigned lg_size_p   = 3,
   parameter int unsigned window_p    = 2 ** lg_size_p,
   parameter int unsigned max_retry_p = 4,
   parameter int unsigned timeout_p   = 64
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 empty_i,
   output logic                 deq_o,
   output logic                 incr_o,
   output logic                 ack_o,
   output logic                 rollback_o,
   output logic                 v_o,
   input  logic                 ready_i,
   input  logic                 resp_v_i,
   input  logic [1:0]           resp_op_i,
   output logic [lg_size_p:0]   outstanding_o,
   output logic                 err_o
);

   localparam int unsigned CntW   = lg_size_p + 1;
   localparam int unsigned RetryW = $clog2(max_retry_p + 1);
   localparam logic [CntW-1:0]   Window   = CntW'(window_p);
   localparam logic [RetryW-1:0] MaxRetry = RetryW'(max_retry_p);

   typedef enum logic [1:0] {StSend, StHold, StRecover} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic              err_q, err_d;
   logic              timeout_fire;
   logic              req;
   logic [1:0]        op;

`ifdef BSG_FIFO_ROLLY_READ_CTRL_TIMEOUT_EN
   localparam int unsigned IdleW = $clog2(timeout_p + 1);
   localparam logic [IdleW-1:0] TimeoutM1 = IdleW'(timeout_p - 1);

   logic [IdleW-1:0] idle_q, idle_d;

   // Self-nack wins over a same-cycle dequeue, just like a consumer nack.
   assign timeout_fire = (state_q != StRecover) && (cnt_q != '0) && !resp_v_i
                         && (idle_q == TimeoutM1);

   always_comb begin
      idle_d = idle_q + IdleW'(1);
      if (resp_v_i || deq_o || rollback_o || (cnt_q == '0) || (state_q == StRecover)) begin
         idle_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) idle_q <= '0;
      else         idle_q <= idle_d;
   end
`else
   assign timeout_fire = 1'b0;
`endif

   assign req = resp_v_i | timeout_fire;
   assign op  = timeout_fire ? 2'd2 : resp_op_i;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retry_d    = retry_q;
      err_d      = err_q;
      v_o        = 1'b0;
      deq_o      = 1'b0;
      incr_o     = 1'b0;
      ack_o      = 1'b0;
      rollback_o = 1'b0;
      if (!reset_i) begin
         if ((state_q != StRecover) && req && (op == 2'd2) && (cnt_q != '0)) begin
            rollback_o = 1'b1;
         end
         v_o   = (state_q == StSend) && !empty_i && !rollback_o && (cnt_q < Window);
         deq_o = v_o && ready_i;
         cnt_d = cnt_q + CntW'(deq_o);
         if (state_q == StRecover) begin
            if (resp_v_i) err_d = 1'b1;
            state_d = StSend;
         end else begin
            if (req) begin
               unique case (op)
                  2'd0: begin
                     if ((cnt_q != '0) || deq_o) begin
                        incr_o  = 1'b1;
                        cnt_d   = deq_o ? cnt_q : cnt_q - CntW'(1);
                        retry_d = '0;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  2'd1: begin
                     // Tracker commits the in-flight deq along with everything outstanding.
                     ack_o   = 1'b1;
                     cnt_d   = CntW'(deq_o);
                     retry_d = '0;
                  end
                  2'd2: begin
                     if (cnt_q != '0) begin
                        cnt_d = '0;
                        if (retry_q != MaxRetry) retry_d = retry_q + RetryW'(1);
                        if (retry_q >= MaxRetry - RetryW'(1)) err_d = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  2'd3: err_d = 1'b1;
               endcase
            end
            if (rollback_o)           state_d = StRecover;
            else if (cnt_d == Window) state_d = StHold;
            else                      state_d = StSend;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StSend;
         cnt_q   <= '0;
         retry_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         err_q   <= err_d;
      end
   end

   assign outstanding_o = cnt_q;
   assign err_o         = err_q;

endmodule

// File: doc/bsg_fifo_rolly_read_ctrl.md
Name: bsg_fifo_rolly_read_ctrl

Overview:
- Read-side controller that sits directly downstream of the rolly FIFO pointer tracker.
- Dequeues entries speculatively onto a valid/ready output channel and tracks how many have been sent but not yet acknowledged.
- Converts consumer responses (release-one, ack-all, nack) into the tracker's deq/incr/ack/rollback strobes, always obeying the tracker's legality rules.
- Enforces a bounded outstanding window and a retry limit.

Parameters:
- lg_size_p, (required), log2 of FIFO depth; must match the tracker.
- window_p, 2**lg_size_p, max dequeued-but-unacked entries; legal range 1..2**lg_size_p.
- max_retry_p, 4, consecutive nacks tolerated before err_o is raised.
- timeout_p, 64, idle cycles before self-rollback (optional feature only).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- empty_i  in  1  tracker empty_o.
- deq_o  out  1  tracker deq_i.
- incr_o  out  1  tracker incr_i.
- ack_o  out  1  tracker ack_i.
- rollback_o  out  1  tracker rollback_i.
- v_o  out  1  output entry valid; data comes from FIFO memory at tracker rptr.
- ready_i  in  1  consumer accepts entry.
- resp_v_i  in  1  response valid; always consumed in the cycle it is valid.
- resp_op_i  in  2  response op: 0=release one oldest, 1=ack all sent, 2=nack/replay, 3=reserved (ignored; sets err_o).
- outstanding_o  out  lg_size_p+1  count of sent-unacked entries.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset: state=SEND, cnt_r=0, retry_r=0, err_o=0. All strobes and v_o are combinationally 0 during reset.
- States:
  - SEND: issue entries normally.
  - HOLD: cnt_r==window_p.
  - RECOVER: one bubble cycle after a rollback.
- v_o = (state==SEND) & ~empty_i & ~rollback_o & (cnt_r<window_p). deq_o = v_o & ready_i. Zero-latency handshake; no registering of data.
- ack-all: ack_o=1, incr_o=0. cnt_n = deq_o (the tracker acks the current deq together with outstanding entries). retry_r←0.
- release-one: legal only if cnt_r>0 or deq_o.
  - incr_o=1, cnt_n = cnt_r + deq_o - 1, retry_r←0.
  - If illegal: incr_o=0 and err_o←1.
- nack:
  - rollback_o=1, deq_o forced 0, cnt_n=0, next state RECOVER.
  - retry_r←retry_r+1, saturating. When it reaches max_retry_p, err_o←1; replay continues.
  - If cnt_r==0: nack is a no-op, err_o←1.
- Invariants: ack_o & (incr_o | rollback_o) is never 1. rollback_o=1 implies deq_o=0. deq_o=0 whenever empty_i=1.
- No response: cnt_n = cnt_r + deq_o.
- Transitions:
  - SEND→HOLD when cnt_n==window_p.
  - HOLD→SEND when cnt_n<window_p.
  - RECOVER→SEND unconditionally after 1 cycle. Responses arriving in RECOVER are ignored and set err_o.
- Width: cnt_r is lg_size_p+1 bits and never exceeds window_p. Tracker pointer wrap is handled in the tracker; this block never computes pointer values.
- Simultaneous deq + ack/release in the same cycle is legal and handled as above. deq + nack cannot both be 1.
- reset_i mid-burst: all state is cleared next edge. The tracker is reset with the same reset_i.

Optional Feature:
- Macro: BSG_FIFO_ROLLY_READ_CTRL_TIMEOUT_EN.
- Defined:
  - An idle counter increments each cycle with cnt_r>0, no resp_v_i and no deq_o. It clears on any response or deq_o.
  - On reaching timeout_p, the block issues a self-nack: identical to resp nack, including retry_r increment.
- Undefined: no counter; the block waits indefinitely for a response.

Test Plan:
- Enqueue 3 entries, ready_i=1, then resp ack-all -> 3 deq_o pulses, outstanding_o 1,2,3; single ack_o cycle; outstanding_o=0; no rollback_o.
- window_p=2, 4 entries, ready_i=1 -> 2 deq_o, v_o=0 in HOLD. release-one -> outstanding_o=1, third entry sent the next cycle.
- 2 sent, nack -> rollback_o=1 with deq_o=0; one RECOVER cycle with v_o=0; then the same 2 entries are re-sent (tracker rptr returns to the same value).
- release-one with outstanding_o=0 and empty_i=1 -> incr_o=0, err_o=1 and stays set until reset.
- max_retry_p=2, three consecutive nacks -> err_o rises after the second nack; the third rollback is still issued.
- Timeout macro on, timeout_p=8, 1 entry sent, no response -> rollback_o pulses 8 cycles after the deq; with the macro off, no rollback after 100 cycles.
